// File: rtl/wave_voice_scheduler.sv
// Shares one 1-cycle wave lookup across NUM_VOICES voices; tick to sample_valid is NUM_VOICES+2 cycles.
// Ticks arriving while busy are dropped and latch overrun; define WAVE_VOICE_SCHED_SCALE_EN to scale the mix by 1/NUM_VOICES instead of saturating.
module wave_voice_scheduler #(
    parameter int NUM_VOICES  = 4,
    parameter int PHASE_WIDTH = 24,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_tick,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic [PHASE_WIDTH-1:0]        cfg_tuning,
    input  logic                          cfg_gate,
    output logic [ADDR_WIDTH-1:0]         wave_addr,
    input  logic [DATA_WIDTH-1:0]         wave_dout,
    output logic [DATA_WIDTH-1:0]         sample_out,
    output logic                          sample_valid,
    output logic                          busy,
    output logic                          overrun
);
    localparam int VW    = $clog2(NUM_VOICES);
    localparam int ACC_W = DATA_WIDTH + VW;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

    state_t                  r_state;
    logic [VW-1:0]           r_idx;
    logic [PHASE_WIDTH-1:0]  r_phase  [NUM_VOICES];
    logic [PHASE_WIDTH-1:0]  r_tuning [NUM_VOICES];
    logic [NUM_VOICES-1:0]   r_gate;
    logic                    r_agate;
    logic                    r_dgate;
    logic signed [ACC_W-1:0] r_acc;
    logic [ADDR_WIDTH-1:0]   r_wave_addr;
    logic [DATA_WIDTH-1:0]   r_sample;
    logic                    r_valid;
    logic                    r_busy;
    logic                    r_overrun;

    logic                    w_idle;
    logic                    w_last;
    logic [VW-1:0]           w_next_voice;
    logic                    w_next_gate;
    logic [ADDR_WIDTH-1:0]   w_next_addr;
    logic signed [ACC_W-1:0] w_add;
    logic signed [ACC_W-1:0] w_sum;
    logic [VW:0]             w_hi;
    logic [DATA_WIDTH-1:0]   w_mix;

    // OUTPUT is the strobe cycle; it behaves as IDLE so a tick there starts the next frame.
    assign w_idle       = (r_state == IDLE) || (r_state == OUTPUT);
    assign w_last       = (r_idx == VW'(NUM_VOICES - 1));
    assign w_next_voice = w_idle ? '0 : r_idx + 1'b1;
    assign w_next_gate  = r_gate[w_next_voice];
    assign w_next_addr  = w_next_gate ? r_phase[w_next_voice][PHASE_WIDTH-1 -: ADDR_WIDTH] : '0;
    assign w_add        = r_dgate ? {{VW{wave_dout[DATA_WIDTH-1]}}, wave_dout} : '0;
    assign w_sum        = r_acc + w_add;
    assign w_hi         = w_sum[ACC_W-1:DATA_WIDTH-1];

    always_comb begin
`ifdef WAVE_VOICE_SCHED_SCALE_EN
        w_mix = w_sum[ACC_W-1:VW];
`else
        w_mix = w_sum[DATA_WIDTH-1:0];
        if (w_hi != '0 && w_hi != '1) begin
            w_mix = w_sum[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
`endif
    end

    // r_agate/r_dgate track whether the address/data currently on the lookup belong to a sounding voice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_agate     <= 1'b0;
            r_dgate     <= 1'b0;
            r_acc       <= '0;
            r_wave_addr <= '0;
            r_sample    <= '0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_dgate <= r_agate;
            if (sample_tick && !w_idle) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                IDLE, OUTPUT: begin
                    r_state <= IDLE;
                    r_agate <= 1'b0;
                    if (sample_tick) begin
                        r_state     <= ISSUE;
                        r_idx       <= '0;
                        r_acc       <= '0;
                        r_busy      <= 1'b1;
                        r_wave_addr <= w_next_addr;
                        r_agate     <= w_next_gate;
                    end
                end
                ISSUE: begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_state <= DRAIN;
                        r_agate <= 1'b0;
                    end else begin
                        r_idx       <= w_next_voice;
                        r_wave_addr <= w_next_addr;
                        r_agate     <= w_next_gate;
                    end
                end
                DRAIN: begin
                    r_state  <= OUTPUT;
                    r_acc    <= w_sum;
                    r_busy   <= 1'b0;
                    r_sample <= w_mix;
                    r_valid  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Later assignments win: a gate-rise clear overrides the same cycle's phase step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_phase[v]  <= '0;
                r_tuning[v] <= '0;
            end
            r_gate <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (r_state == ISSUE && r_idx == VW'(v)) begin
                    r_phase[v] <= r_gate[v] ? r_phase[v] + r_tuning[v] : '0;
                end
                if (cfg_we && cfg_voice == VW'(v)) begin
                    r_tuning[v] <= cfg_tuning;
                    r_gate[v]   <= cfg_gate;
                    if (cfg_gate && !r_gate[v]) begin
                        r_phase[v] <= '0;
                    end
                end
            end
        end
    end

    assign wave_addr    = r_wave_addr;
    assign sample_out   = r_sample;
    assign sample_valid = r_valid;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule
